// File: rtl/l1_rd_burst_port.sv
// rtl/l1_rd_burst_port.sv - L1 read port with burst sequencing, per-beat pointer update and discard flag.
// Optional beat/discard statistics counters: define L1_RD_BURST_PORT_STATS_EN.
module l1_rd_burst_port #(
    parameter int nstrms       = 64,
    parameter int nstrms_width = $clog2(nstrms),
    parameter int nports       = 8,
    parameter int portid       = 0,
    parameter int ptr_width    = 4,
    parameter int cl_size      = 8,
    parameter int clofs_width  = $clog2(cl_size),
    parameter int max_len      = 4,
    parameter int len_width    = $clog2(max_len + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [nstrms-1:0]               i_rst_end,
    input  logic [nstrms-1:0]               i_l1_end,
    input  logic [nstrms-1:0]               i_single_v,
    input  logic                            i_rd_v,
    output logic                            i_rd_r,
    input  logic [nstrms_width-1:0]         i_rd_sid,
    input  logic [len_width-1:0]            i_rd_len,
    input  logic [nports-1:0]               i_rd_acts,
    input  logic [nports*nstrms_width-1:0]  i_rd_sids,
    output logic                            o_rd_act,
    input  logic [nstrms*ptr_width-1:0]     i_ptrs,
    output logic                            o_addr_v,
    input  logic                            o_addr_r,
    output logic [ptr_width-1:0]            o_addr_ptr,
    output logic [nstrms_width-1:0]         o_addr_sid,
    output logic                            o_addr_last,
    output logic                            o_addr_discard,
    output logic [nstrms-1:0]               o_req_v,
    input  logic [nstrms-1:0]               o_req_r,
    output logic [31:0]                     o_stat_beats,
    output logic [31:0]                     o_stat_discard
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;
    localparam logic [len_width-1:0] MAX_LEN_L = len_width'(max_len);

    logic [0:0]              state_q, state_d;
    logic [nstrms_width-1:0] sid_q, sid_d;
    logic [len_width-1:0]    len_q, len_d;
    logic [len_width-1:0]    beat_q, beat_d;
    logic                    addr_done_q, addr_done_d;
    logic                    req_done_q, req_done_d;
    logic                    disc_q, disc_d;

    logic                    in_burst, last_beat, beat_disc;
    logic                    addr_v, req_v, addr_fire, req_fire, beat_done, accept;
    logic [ptr_width-1:0]    ofs_cnt, beat_ptr;
    logic [len_width-1:0]    acc_len;

    // Lower-indexed ports reading the same stream this cycle consume pointer slots ahead of us.
    always_comb begin
        ofs_cnt = '0;
        for (int j = 0; j < nports; j++) begin
            if (j < portid && i_rd_acts[j] &&
                i_rd_sids[j*nstrms_width +: nstrms_width] == sid_q)
                ofs_cnt = ofs_cnt + ptr_width'(1);
        end
    end

    assign in_burst  = (state_q == ST_BURST);
    assign beat_ptr  = i_ptrs[sid_q*ptr_width +: ptr_width] + ofs_cnt;
    assign beat_disc = i_l1_end[sid_q] |
                       (i_rst_end[sid_q] & i_single_v[sid_q] & beat_ptr[clofs_width]) |
                       disc_q;
    assign last_beat = (beat_q == len_q - len_width'(1));
    assign addr_v    = in_burst & ~addr_done_q;
    assign req_v     = in_burst & ~req_done_q & ~beat_disc;
    assign addr_fire = addr_v & o_addr_r;
    assign req_fire  = req_v & o_req_r[sid_q];
    // A discarded beat has no pointer update, so its req flow is trivially complete.
    assign beat_done = in_burst & (addr_done_q | addr_fire) &
                       (req_done_q | req_fire | beat_disc);
    assign i_rd_r    = ~reset & (~in_burst | (beat_done & last_beat));
    assign accept    = i_rd_v & i_rd_r;
    assign acc_len   = (i_rd_len == '0) ? len_width'(1) :
                       (i_rd_len > MAX_LEN_L) ? MAX_LEN_L : i_rd_len;

    always_comb begin
        state_d     = state_q;
        sid_d       = sid_q;
        len_d       = len_q;
        beat_d      = beat_q;
        addr_done_d = addr_done_q | addr_fire;
        req_done_d  = req_done_q | req_fire;
        disc_d      = disc_q | (in_burst & beat_disc);
        if (beat_done) begin
            addr_done_d = 1'b0;
            req_done_d  = 1'b0;
            beat_d      = beat_q + len_width'(1);
            if (last_beat) begin
                beat_d  = '0;
                disc_d  = 1'b0;
                state_d = ST_IDLE;
            end
        end
        if (accept) begin
            state_d = ST_BURST;
            sid_d   = i_rd_sid;
            len_d   = acc_len;
            beat_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sid_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            addr_done_q <= 1'b0;
            req_done_q  <= 1'b0;
            disc_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sid_q       <= sid_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            addr_done_q <= addr_done_d;
            req_done_q  <= req_done_d;
            disc_q      <= disc_d;
        end
    end

    assign o_addr_v       = addr_v;
    assign o_addr_ptr     = addr_v ? beat_ptr : '0;
    assign o_addr_sid     = addr_v ? sid_q : '0;
    assign o_addr_last    = addr_v & last_beat;
    assign o_addr_discard = addr_v & beat_disc;
    assign o_req_v        = req_v ? ({{(nstrms-1){1'b0}}, 1'b1} << sid_q) : '0;
    assign o_rd_act       = |o_req_v;

`ifdef L1_RD_BURST_PORT_STATS_EN
    logic [31:0] beats_q, beats_d, discs_q, discs_d;

    always_comb begin
        beats_d = beats_q;
        discs_d = discs_q;
        if (beat_done && !beat_disc && beats_q != 32'hFFFF_FFFF) beats_d = beats_q + 32'd1;
        if (beat_done && beat_disc && discs_q != 32'hFFFF_FFFF) discs_d = discs_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beats_q <= '0;
            discs_q <= '0;
        end else begin
            beats_q <= beats_d;
            discs_q <= discs_d;
        end
    end

    assign o_stat_beats   = beats_q;
    assign o_stat_discard = discs_q;
`else
    assign o_stat_beats   = 32'd0;
    assign o_stat_discard = 32'd0;
`endif

    logic unused_rd;
    assign unused_rd = ^{i_rd_acts, i_rd_sids};
endmodule

// File: tb/tb_l1_rd_burst_port.sv
// tb/tb_l1_rd_burst_port.sv - directed self-checking bench for l1_rd_burst_port (portid=2).
module tb_l1_rd_burst_port;
    localparam int NS = 64, SW = 6, NP = 8, PW = 4, LW = 3;

    logic            clk, reset;
    logic [NS-1:0]   i_rst_end, i_l1_end, i_single_v;
    logic            i_rd_v, i_rd_r;
    logic [SW-1:0]   i_rd_sid;
    logic [LW-1:0]   i_rd_len;
    logic [NP-1:0]   i_rd_acts;
    logic [NP*SW-1:0] i_rd_sids;
    logic            o_rd_act;
    logic [NS*PW-1:0] i_ptrs;
    logic            o_addr_v, o_addr_r;
    logic [PW-1:0]   o_addr_ptr;
    logic [SW-1:0]   o_addr_sid;
    logic            o_addr_last, o_addr_discard;
    logic [NS-1:0]   o_req_v, o_req_r;
    logic [31:0]     o_stat_beats, o_stat_discard;

    int errors = 0;
    int checks = 0;

    l1_rd_burst_port #(.portid(2)) dut (
        .clk(clk), .reset(reset),
        .i_rst_end(i_rst_end), .i_l1_end(i_l1_end), .i_single_v(i_single_v),
        .i_rd_v(i_rd_v), .i_rd_r(i_rd_r), .i_rd_sid(i_rd_sid), .i_rd_len(i_rd_len),
        .i_rd_acts(i_rd_acts), .i_rd_sids(i_rd_sids), .o_rd_act(o_rd_act),
        .i_ptrs(i_ptrs),
        .o_addr_v(o_addr_v), .o_addr_r(o_addr_r), .o_addr_ptr(o_addr_ptr),
        .o_addr_sid(o_addr_sid), .o_addr_last(o_addr_last), .o_addr_discard(o_addr_discard),
        .o_req_v(o_req_v), .o_req_r(o_req_r),
        .o_stat_beats(o_stat_beats), .o_stat_discard(o_stat_discard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ptr(input int sid, input logic [PW-1:0] v);
        i_ptrs[sid*PW +: PW] = v;
    endtask

    task automatic beat(input string tag, input logic [PW-1:0] ptr, input logic [SW-1:0] sid,
                        input logic last, input logic disc);
        chk({tag, "_addr_v"}, 64'(o_addr_v), 64'd1);
        chk({tag, "_ptr"}, 64'(o_addr_ptr), 64'(ptr));
        chk({tag, "_sid"}, 64'(o_addr_sid), 64'(sid));
        chk({tag, "_last"}, 64'(o_addr_last), 64'(last));
        chk({tag, "_disc"}, 64'(o_addr_discard), 64'(disc));
        chk({tag, "_req_v"}, 64'(o_req_v), disc ? 64'd0 : (64'd1 << sid));
    endtask

    task automatic request(input logic [SW-1:0] sid, input logic [LW-1:0] len);
        i_rd_v   = 1'b1;
        i_rd_sid = sid;
        i_rd_len = len;
    endtask

    initial begin
        reset = 1'b1;
        i_rst_end = '0; i_l1_end = '0; i_single_v = '0;
        i_rd_v = 1'b0; i_rd_sid = '0; i_rd_len = '0;
        i_rd_acts = '0; i_rd_sids = '0; i_ptrs = '0;
        o_addr_r = 1'b1; o_req_r = '1;
        #1;
        chk("rst_rd_r", 64'(i_rd_r), 64'd0);
        chk("rst_addr_v", 64'(o_addr_v), 64'd0);
        chk("rst_req_v", 64'(o_req_v), 64'd0);
        chk("rst_stat_b", 64'(o_stat_beats), 64'd0);
        step(); step();
        reset = 1'b0;
        #1;
        chk("idle_rd_r", 64'(i_rd_r), 64'd1);

        // single beat, sid 5
        set_ptr(5, 4'd3);
        request(6'd5, 3'd1);
        #1 chk("t1_rd_r", 64'(i_rd_r), 64'd1);
        step();
        i_rd_v = 1'b0;
        beat("t1", 4'd3, 6'd5, 1'b1, 1'b0);
        chk("t1_rd_act", 64'(o_rd_act), 64'd1);
        chk("t1_rd_r_last", 64'(i_rd_r), 64'd1);
        step();
        chk("t1_idle", 64'(o_addr_v), 64'd0);

        // sid 2 len 3 followed back-to-back by sid 7 len 1
        set_ptr(2, 4'd0);
        set_ptr(7, 4'd10);
        request(6'd2, 3'd3);
        step();
        request(6'd7, 3'd1);
        beat("t2b0", 4'd0, 6'd2, 1'b0, 1'b0);
        chk("t2b0_rd_r", 64'(i_rd_r), 64'd0);
        step(); set_ptr(2, 4'd1); #1;
        beat("t2b1", 4'd1, 6'd2, 1'b0, 1'b0);
        chk("t2b1_rd_r", 64'(i_rd_r), 64'd0);
        step(); set_ptr(2, 4'd2); #1;
        beat("t2b2", 4'd2, 6'd2, 1'b1, 1'b0);
        chk("t2b2_rd_r", 64'(i_rd_r), 64'd1);
        step();
        i_rd_v = 1'b0;
        beat("t2s7", 4'd10, 6'd7, 1'b1, 1'b0);
        step();
        chk("t2_idle", 64'(o_addr_v), 64'd0);

        // lower ports 0 and 1 active on sid 4 -> offset 2
        set_ptr(4, 4'd6);
        i_rd_acts = 8'h03;
        i_rd_sids[0*SW +: SW] = 6'd4;
        i_rd_sids[1*SW +: SW] = 6'd4;
        i_rd_sids[2*SW +: SW] = 6'd4;
        i_rd_sids[3*SW +: SW] = 6'd4;
        i_rd_acts[3] = 1'b1;
        request(6'd4, 3'd1);
        step();
        i_rd_v = 1'b0;
        beat("t3", 4'd8, 6'd4, 1'b1, 1'b0);
        step();
        // only port 0 matches; len 0 treated as 1
        i_rd_sids[1*SW +: SW] = 6'd9;
        request(6'd4, 3'd0);
        step();
        i_rd_v = 1'b0;
        beat("t3b", 4'd7, 6'd4, 1'b1, 1'b0);
        step();
        chk("t3b_idle", 64'(o_addr_v), 64'd0);
        i_rd_acts = '0;

        // L1 ended on sid 9: whole burst discarded
        i_l1_end[9] = 1'b1;
        request(6'd9, 3'd2);
        step();
        i_rd_v = 1'b0;
        beat("t4b0", 4'd0, 6'd9, 1'b0, 1'b1);
        chk("t4b0_rd_act", 64'(o_rd_act), 64'd0);
        step();
        beat("t4b1", 4'd0, 6'd9, 1'b1, 1'b1);
        step();
        i_l1_end[9] = 1'b0;
        chk("t4_idle", 64'(o_addr_v), 64'd0);

        // carry-bit discard on beat 2, latch holds for beat 3
        i_rst_end[1] = 1'b1;
        i_single_v[1] = 1'b1;
        set_ptr(1, 4'd7);
        request(6'd1, 3'd3);
        step();
        i_rd_v = 1'b0;
        beat("t5b0", 4'd7, 6'd1, 1'b0, 1'b0);
        step(); set_ptr(1, 4'd8); #1;
        beat("t5b1", 4'd8, 6'd1, 1'b0, 1'b1);
        step(); set_ptr(1, 4'd0); #1;
        beat("t5b2", 4'd0, 6'd1, 1'b1, 1'b1);
        step();
        request(6'd1, 3'd1);
        step();
        i_rd_v = 1'b0;
        beat("t5n", 4'd0, 6'd1, 1'b1, 1'b0);
        step();
        i_rst_end[1] = 1'b0;
        i_single_v[1] = 1'b0;

`ifdef L1_RD_BURST_PORT_STATS_EN
        chk("stat_beats", 64'(o_stat_beats), 64'd9);
        chk("stat_disc", 64'(o_stat_discard), 64'd4);
`else
        chk("stat_beats", 64'(o_stat_beats), 64'd0);
        chk("stat_disc", 64'(o_stat_discard), 64'd0);
`endif

        // address back-pressure for 3 cycles, then reset mid-burst
        set_ptr(3, 4'd5);
        o_addr_r = 1'b0;
        request(6'd3, 3'd2);
        step();
        i_rd_v = 1'b0;
        beat("t6c0", 4'd5, 6'd3, 1'b0, 1'b0);
        step();
        chk("t6c1_addr_v", 64'(o_addr_v), 64'd1);
        chk("t6c1_ptr", 64'(o_addr_ptr), 64'd5);
        chk("t6c1_req_v", 64'(o_req_v), 64'd0);
        step();
        chk("t6c2_addr_v", 64'(o_addr_v), 64'd1);
        chk("t6c2_ptr", 64'(o_addr_ptr), 64'd5);
        chk("t6c2_req_v", 64'(o_req_v), 64'd0);
        o_addr_r = 1'b1;
        step();
        beat("t6b1", 4'd5, 6'd3, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk("t6r_addr_v", 64'(o_addr_v), 64'd0);
        chk("t6r_req_v", 64'(o_req_v), 64'd0);
        chk("t6r_rd_r", 64'(i_rd_r), 64'd0);
        chk("t6r_rd_act", 64'(o_rd_act), 64'd0);
        chk("t6r_stat", 64'(o_stat_beats), 64'd0);
        step();
        reset = 1'b0;
        step();
        chk("t6_idle_addr_v", 64'(o_addr_v), 64'd0);
        chk("t6_idle_rd_r", 64'(i_rd_r), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
